// File: rtl/sha256_pkg.sv
// Shared widths, sequencer states and the SHA-256 small-sigma functions
// used by the message-schedule writer.
package sha256_pkg;

   localparam int WORD_W     = 32;
   localparam int ADDR_W     = 6;
   localparam int NUM_WORDS  = 64;
   localparam int LOAD_WORDS = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RD16 = 3'd2,
      RD15 = 3'd3,
      RD7  = 3'd4,
      RD2  = 3'd5,
      DONE = 3'd6
   } state_t;

   function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// Combinational SHA-256 small sigma; SEL=0 gives s0, SEL=1 gives s1.
module sha256_small_sigma
   import sha256_pkg::*;
#(
   parameter bit SEL = 1'b0
) (
   input  logic [WORD_W-1:0] i_x,
   output logic [WORD_W-1:0] o_y
);

   assign o_y = SEL ? sig1(i_x) : sig0(i_x);

endmodule

// File: rtl/sha256_sched_writer.sv
// Loads W[0..15] from a valid/ready stream into the schedule regfile, then
// expands W[16..63] in place, one read and at most one write per cycle.
module sha256_sched_writer
   import sha256_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [WORD_W-1:0] i_in_data,
   output logic              o_rf_we,
   output logic [ADDR_W-1:0] o_rf_waddr,
   output logic [WORD_W-1:0] o_rf_wdata,
   output logic [ADDR_W-1:0] o_rf_raddr,
   input  logic [WORD_W-1:0] i_rf_rdata,
   output logic              o_busy,
   output logic              o_done,
   output logic [2:0]        o_dbg_state
);

   // Input stream: a word transfers on any cycle where i_in_valid && o_in_ready;
   // o_in_ready is high for every LOAD cycle and never depends on i_in_valid.

   localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(LOAD_WORDS - 1);
   localparam logic [ADDR_W-1:0] T_LAST    = ADDR_W'(NUM_WORDS - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_t;
   logic [ADDR_W-1:0]   w_t_next;
   logic [WORD_W-1:0]   r_acc;
   logic [WORD_W-1:0]   w_acc_next;
   logic [WORD_W-1:0]   w_s0;
   logic [WORD_W-1:0]   w_s1;

   sha256_small_sigma #(.SEL(1'b0)) u_sigma0 (.i_x(i_rf_rdata), .o_y(w_s0));
   sha256_small_sigma #(.SEL(1'b1)) u_sigma1 (.i_x(i_rf_rdata), .o_y(w_s1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_t     <= '0;
         r_acc   <= '0;
      end else begin
         r_state <= w_state_next;
         r_t     <= w_t_next;
         r_acc   <= w_acc_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_t_next     = r_t;
      w_acc_next   = r_acc;
      o_in_ready   = 1'b0;
      o_rf_we      = 1'b0;
      o_rf_waddr   = '0;
      o_rf_wdata   = '0;
      o_rf_raddr   = '0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_next = LOAD;
               w_t_next     = '0;
            end
         end
         LOAD: begin
            o_busy     = 1'b1;
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               o_rf_we    = 1'b1;
               o_rf_waddr = r_t;
               o_rf_wdata = i_in_data;
               w_t_next   = r_t + 1'b1;
               if (r_t == LOAD_LAST) w_state_next = RD16;
            end
         end
         // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], one operand per cycle.
         RD16: begin
            o_busy       = 1'b1;
            o_rf_raddr   = r_t - ADDR_W'(16);
            w_acc_next   = i_rf_rdata;
            w_state_next = RD15;
         end
         RD15: begin
            o_busy       = 1'b1;
            o_rf_raddr   = r_t - ADDR_W'(15);
            w_acc_next   = r_acc + w_s0;
            w_state_next = RD7;
         end
         RD7: begin
            o_busy       = 1'b1;
            o_rf_raddr   = r_t - ADDR_W'(7);
            w_acc_next   = r_acc + i_rf_rdata;
            w_state_next = RD2;
         end
         RD2: begin
            o_busy     = 1'b1;
            o_rf_raddr = r_t - ADDR_W'(2);
            o_rf_we    = 1'b1;
            o_rf_waddr = r_t;
            o_rf_wdata = r_acc + w_s1;
            if (r_t == T_LAST) begin
               w_state_next = DONE;
            end else begin
               w_t_next     = r_t + 1'b1;
               w_state_next = RD16;
            end
         end
         DONE: begin
            o_done       = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sha256_sched_writer.sv
// Directed and random checks of the schedule writer against a behavioural
// regfile and an independent schedule model.
module tb_sha256_sched_writer;
   import sha256_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        i_start;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [31:0] i_in_data;
   logic        o_rf_we;
   logic [5:0]  o_rf_waddr;
   logic [31:0] o_rf_wdata;
   logic [5:0]  o_rf_raddr;
   logic [31:0] i_rf_rdata;
   logic        o_busy;
   logic        o_done;
   logic [2:0]  o_dbg_state;

   sha256_sched_writer u_dut (
      .clock      (clock),
      .reset      (reset),
      .i_start    (i_start),
      .i_in_valid (i_in_valid),
      .o_in_ready (o_in_ready),
      .i_in_data  (i_in_data),
      .o_rf_we    (o_rf_we),
      .o_rf_waddr (o_rf_waddr),
      .o_rf_wdata (o_rf_wdata),
      .o_rf_raddr (o_rf_raddr),
      .i_rf_rdata (i_rf_rdata),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_dbg_state(o_dbg_state)
   );

   always #5 clock = ~clock;

   logic [31:0] rf [64];
   assign i_rf_rdata = rf[o_rf_raddr];
   always @(posedge clock) if (o_rf_we) rf[o_rf_waddr] <= o_rf_wdata;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] blk [16];
   logic [31:0] ref_w [64];
   logic [31:0] exp_q [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic build_ref();
      exp_q.delete();
      for (int i = 0; i < 64; i++) begin
         if (i < 16) ref_w[i] = blk[i];
         else ref_w[i] = (rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10))
                       + ref_w[i-7]
                       + (rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3))
                       + ref_w[i-16];
         exp_q.push_back(ref_w[i]);
         rf[i] = 32'h0;
      end
   endtask

   task automatic run_block(input int stall_at, input int stall_len, input bit pulse_start,
                            input int abort_cyc, output int done_cyc, output int we_cnt,
                            output int done_cnt);
      int          cyc;
      int          wi;
      int          stalled;
      bit          fin;
      bit          stall_now;
      logic [31:0] e;
      build_ref();
      @(negedge clock);
      i_start = 1'b1; i_in_valid = 1'b0; i_in_data = '0;
      cyc = 0; wi = 0; stalled = 0; we_cnt = 0; done_cnt = 0; done_cyc = -1; fin = 1'b0;
      #1 check_eq("busy_at_start", o_busy, 1'b0);
      while (!fin && cyc < 400) begin
         @(negedge clock);
         cyc++;
         i_start    = pulse_start && (cyc == 3 || cyc == 19 || cyc == 209);
         i_in_valid = 1'b0;
         i_in_data  = '0;
         stall_now  = (wi == stall_at) && (stalled < stall_len);
         if (stall_now) stalled++;
         else if (wi < 16) begin
            i_in_valid = 1'b1;
            i_in_data  = blk[wi];
         end
         #1;
         if (cyc == 1) check_eq("busy_cycle1", o_busy, 1'b1);
         if (stall_now) begin
            check_eq("stall_ready", o_in_ready, 1'b1);
            check_eq("stall_we", o_rf_we, 1'b0);
         end
         if (i_in_valid && o_in_ready) wi++;
         if (o_rf_we) begin
            we_cnt++;
            if (o_dbg_state == 3'(RD2)) check_eq("waddr_ne_raddr", o_rf_waddr != o_rf_raddr, 1'b1);
            if (exp_q.size() == 0) check_eq("extra_write", 1'b1, 1'b0);
            else begin
               e = exp_q.pop_front();
               check_eq("wdata", o_rf_wdata, e);
               check_eq("waddr", o_rf_waddr, 32'(63 - exp_q.size()));
            end
         end
         if (o_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            check_eq("idle_after_done", o_dbg_state, 3'(IDLE));
            check_eq("busy_after_done", o_busy, 1'b0);
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1'b1;
         if (cyc == abort_cyc) begin
            check_eq("abort_state", o_dbg_state, 3'(RD15));
            reset = 1'b1;
            #1;
            check_eq("abort_outs",
                     {o_in_ready, o_rf_we, o_busy, o_done, o_dbg_state, o_rf_raddr, o_rf_waddr},
                     32'h0);
            check_eq("abort_wdata", o_rf_wdata, 32'h0);
            for (int k = 0; k < 3; k++) begin
               @(negedge clock);
               check_eq("abort_no_we", {o_rf_we, o_done}, 2'b00);
            end
            reset = 1'b0;
            fin   = 1'b1;
         end
      end
      i_start = 1'b0; i_in_valid = 1'b0; i_in_data = '0;
      if (!fin) check_eq("timeout", 1'b0, 1'b1);
   endtask

   task automatic load_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   initial begin
      int dc, wc, dn, nz;
      reset = 1'b1; i_start = 1'b1; i_in_valid = 1'b1; i_in_data = 32'hFFFF_FFFF;
      repeat (3) @(negedge clock);
      #1;
      check_eq("rst_ctrl", {o_in_ready, o_rf_we, o_busy, o_done}, 4'b0000);
      check_eq("rst_state", o_dbg_state, 3'(IDLE));
      check_eq("rst_addr", {o_rf_raddr, o_rf_waddr}, 12'h000);
      check_eq("rst_wdata", o_rf_wdata, 32'h0);
      reset = 1'b0; i_start = 1'b0; i_in_valid = 1'b0; i_in_data = '0;
      @(negedge clock);

      load_abc();
      run_block(-1, 0, 1'b0, -1, dc, wc, dn);
      check_eq("abc_done_cyc", dc, 209);
      check_eq("abc_we_cnt", wc, 64);
      check_eq("abc_done_cnt", dn, 1);
      check_eq("abc_w16", rf[16], 32'h61626380);
      check_eq("abc_w17", rf[17], 32'h000F0000);
      check_eq("abc_w18", rf[18], 32'h7DA86405);
      check_eq("abc_w63", rf[63], 32'h12B1EDEB);

      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      run_block(-1, 0, 1'b0, -1, dc, wc, dn);
      nz = 0;
      for (int i = 0; i < 64; i++) if (rf[i] != 32'h0) nz++;
      check_eq("zero_nonzero_words", nz, 0);
      check_eq("zero_we_cnt", wc, 64);
      check_eq("zero_done_cnt", dn, 1);

      load_abc();
      run_block(6, 3, 1'b0, -1, dc, wc, dn);
      check_eq("stall_done_cyc", dc, 212);
      check_eq("stall_we_cnt", wc, 64);
      check_eq("stall_w63", rf[63], 32'h12B1EDEB);

      load_abc();
      run_block(-1, 0, 1'b1, -1, dc, wc, dn);
      check_eq("start_done_cyc", dc, 209);
      check_eq("start_done_cnt", dn, 1);
      check_eq("start_we_cnt", wc, 64);
      check_eq("start_w63", rf[63], 32'h12B1EDEB);

      load_abc();
      run_block(-1, 0, 1'b0, 74, dc, wc, dn);
      check_eq("abort_done_cnt", dn, 0);
      load_abc();
      run_block(-1, 0, 1'b0, -1, dc, wc, dn);
      check_eq("rerun_done_cyc", dc, 209);
      check_eq("rerun_w63", rf[63], 32'h12B1EDEB);

      for (int r = 0; r < 200; r++) begin
         for (int i = 0; i < 16; i++) blk[i] = $urandom_range(32'hFFFF_FFFF, 0);
         run_block(-1, 0, 1'b0, -1, dc, wc, dn);
         check_eq("rand_we_cnt", wc, 64);
         check_eq("rand_done_cnt", dn, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
